// File: rtl/cpu_operand_stage.sv
// RV32I operand stage: decodes the instruction, reads the regfile, builds immediates and registers ALU operands.
// Optional macro CPU_OPERAND_BYPASS_EN forwards a same-cycle writeback into operand reads and hazard checks.
module cpu_operand_stage #(
    parameter bit RESET_PC_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_funct7,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_opcode,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_rs2_value,
    output logic [4:0]  out_rd,
    output logic        out_rd_en,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic [31:0] regs [1:31];
    logic [31:1] pend;
    logic [31:1] pend_live;
    logic [31:1] wb_clear;
    logic [31:1] pend_set;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic        dec_rd_en;
    logic        dec_illegal;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [2:0]  dec_f3;
    logic [6:0]  dec_f7;

    logic        wb_fire;
    logic        hazard;
    logic        accept;

    assign opcode = in_instruction[6:0];
    assign rd     = in_instruction[11:7];
    assign f3     = in_instruction[14:12];
    assign rs1    = in_instruction[19:15];
    assign rs2    = in_instruction[24:20];
    assign f7     = in_instruction[31:25];

    assign imm_i = {{20{in_instruction[31]}}, in_instruction[31:20]};
    assign imm_s = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
    assign imm_u = {in_instruction[31:12], 12'b0};

    assign wb_fire = wb_en && (wb_rd != 5'd0);

    always_comb begin
        wb_clear = '0;
        if (wb_fire) begin
            wb_clear[wb_rd] = 1'b1;
        end
    end

`ifdef CPU_OPERAND_BYPASS_EN
    // A register being written back this cycle is already safe to read.
    assign pend_live = pend & ~wb_clear;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = (wb_fire && (wb_rd == rs1)) ? wb_data : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = (wb_fire && (wb_rd == rs2)) ? wb_data : regs[rs2];
        end
    end
`else
    assign pend_live = pend;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) begin
            rs1_val = regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rs2_val = regs[rs2];
        end
    end
`endif

    always_comb begin
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        writes_rd   = 1'b0;
        dec_illegal = 1'b0;
        dec_a       = '0;
        dec_b       = '0;
        dec_f3      = '0;
        dec_f7      = '0;
        case (opcode)
            OPC_OP: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writes_rd = 1'b1;
                dec_a     = rs1_val;
                dec_b     = rs2_val;
                dec_f3    = f3;
                dec_f7    = f7;
            end
            OPC_OP_IMM: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                dec_a     = rs1_val;
                dec_b     = imm_i;
                dec_f3    = f3;
                dec_f7    = f7;
            end
            OPC_LUI: begin
                writes_rd = 1'b1;
                dec_b     = imm_u;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                dec_a     = in_pc;
                dec_b     = imm_u;
            end
            OPC_LOAD: begin
                use_rs1   = 1'b1;
                writes_rd = 1'b1;
                dec_a     = rs1_val;
                dec_b     = imm_i;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_a   = rs1_val;
                dec_b   = imm_s;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign dec_rd_en = writes_rd && (rd != 5'd0);

    assign hazard = (use_rs1 && (rs1 != 5'd0) && pend_live[rs1]) ||
                    (use_rs2 && (rs2 != 5'd0) && pend_live[rs2]) ||
                    (dec_rd_en && pend_live[rd]);

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        pend_set = '0;
        if (accept && dec_rd_en) begin
            pend_set[rd] = 1'b1;
        end
    end

    // Set is applied after clear so a same-index set/clear leaves the bit pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~wb_clear) | pend_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wb_fire) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_funct7    <= '0;
            out_funct3    <= '0;
            out_opcode    <= '0;
            out_a         <= '0;
            out_b         <= '0;
            out_rs2_value <= '0;
            out_rd        <= '0;
            out_rd_en     <= 1'b0;
            out_illegal   <= 1'b0;
            if (RESET_PC_ZERO) begin
                out_pc <= '0;
            end
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_funct7    <= dec_f7;
            out_funct3    <= dec_f3;
            out_opcode    <= opcode;
            out_a         <= dec_a;
            out_b         <= dec_b;
            out_rs2_value <= rs2_val;
            out_rd        <= rd;
            out_rd_en     <= dec_rd_en;
            out_pc        <= in_pc;
            out_illegal   <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
